// File: rtl/axis_filter_pkg.sv
// Shared types for the AXI-Stream image filter core: run-time filter modes
// and the frame-sequencing FSM states.
package axis_filter_pkg;

    // Run-time per-channel operation, encoded as driven on ctrl_mode.
    typedef enum logic [1:0] {
        PASS   = 2'd0,
        INVERT = 2'd1,
        THRESH = 2'd2,
        HBLUR  = 2'd3
    } mode_e;

    // Frame sequencing: RUN accepts input beats, DRAIN waits for the final
    // beat to leave the output register.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/axis_image_filter_core_if.sv
// AXI-Stream video bundle (data, start-of-frame in tuser, end-of-line in tlast).
interface axis_image_filter_core_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_filter_chan_op.sv
// One colour channel of the filter: mode mux plus a two-deep pixel history
// feeding the 1-2-1 horizontal blur. The result is combinational; the top
// registers it together with the regenerated framing.
module axis_filter_chan_op
    import axis_filter_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            advance,     // an input beat is accepted this cycle
    input  logic            first_col,   // current beat is column 0
    input  logic            second_col,  // current beat is column 1
    input  mode_e           mode,
    input  logic [CH_W-1:0] thresh,
    input  logic [CH_W-1:0] pix_in,
    output logic [CH_W-1:0] pix_out
);

    logic [CH_W-1:0] hist1_reg;   // x[c-1]
    logic [CH_W-1:0] hist2_reg;   // x[c-2]
    logic [CH_W-1:0] tap1;
    logic [CH_W-1:0] tap2;
    logic [CH_W+1:0] blur_sum;

    // Shift the history on every accepted beat; stale history across a row
    // boundary is never used because the left-edge taps override it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hist1_reg <= '0;
            hist2_reg <= '0;
        end else if (advance) begin
            hist1_reg <= pix_in;
            hist2_reg <= hist1_reg;
        end
    end

    // Left-edge replication, blur adder (two spare bits, cannot overflow) and mode mux.
    always_comb begin
        tap1 = hist1_reg;
        tap2 = hist2_reg;
        if (first_col) begin
            tap1 = pix_in;
            tap2 = pix_in;
        end else if (second_col) begin
            tap2 = hist1_reg;
        end
        blur_sum = {2'b00, tap2} + {1'b0, tap1, 1'b0} + {2'b00, pix_in} + (CH_W+2)'(2);
        pix_out  = pix_in;
        case (mode)
            PASS:    pix_out = pix_in;
            INVERT:  pix_out = ~pix_in;
            THRESH:  pix_out = (pix_in >= thresh) ? '1 : '0;
            HBLUR:   pix_out = blur_sum[CH_W+1:2];
            default: pix_out = pix_in;
        endcase
    end

endmodule

// File: rtl/axis_image_filter_core.sv
// AXI-Stream pixel filter core: frame FSM, column/row counters, framing
// regeneration and error flags, one output register stage, and CHANNELS
// independent channel operators.
module axis_image_filter_core
    import axis_filter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 8,
    parameter int DIM_W    = 12
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             ctrl_start,
    input  logic [1:0]       ctrl_mode,
    input  logic [CH_W-1:0]  ctrl_thresh,
    input  logic [DIM_W-1:0] ctrl_cols,
    input  logic [DIM_W-1:0] ctrl_rows,
    output logic             ctrl_busy,
    output logic             ctrl_done,
    input  logic             irq_clear,
    output logic             interrupt,
    output logic             err_sof,
    output logic             err_eol,
    axis_image_filter_core_if.slave  s_axis,
    axis_image_filter_core_if.master m_axis
);

    localparam int DATA_W = CHANNELS * CH_W;

    state_e             state_reg, state_next;
    mode_e              mode_reg;
    logic [CH_W-1:0]    thresh_reg;
    logic [DIM_W-1:0]   cols_reg, rows_reg;
    logic [DIM_W-1:0]   col_reg, row_reg;
    logic               m_valid_reg, m_user_reg, m_last_reg;
    logic [DATA_W-1:0]  m_data_reg;
    logic               done_reg, irq_reg, err_sof_reg, err_eol_reg;
    logic [DATA_W-1:0]  filt_data;

    logic s_ready, s_hs, m_hs, out_free;
    logic last_col, last_row, first_pix, start_ok, zero_dim, done_event;

    assign out_free  = !m_valid_reg || m_axis.tready;
    assign s_ready   = (state_reg == RUN) && out_free;
    assign s_hs      = s_ready && s_axis.tvalid;
    assign m_hs      = m_valid_reg && m_axis.tready;
    assign last_col  = (col_reg == cols_reg - 1'b1);
    assign last_row  = (row_reg == rows_reg - 1'b1);
    assign first_pix = (row_reg == '0) && (col_reg == '0);
    assign zero_dim  = (ctrl_cols == '0) || (ctrl_rows == '0);
    assign start_ok  = (state_reg == IDLE) && ctrl_start;

    // Next-state logic; done_event marks the edge on which a frame completes.
    always_comb begin
        state_next = state_reg;
        done_event = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ctrl_start) begin
                    if (zero_dim) done_event = 1'b1;
                    else          state_next = RUN;
                end
            end
            RUN: begin
                if (s_hs && last_col && last_row) state_next = DRAIN;
            end
            DRAIN: begin
                if (m_hs) begin
                    state_next = IDLE;
                    done_event = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Latch the frame configuration when a start is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_reg   <= PASS;
            thresh_reg <= '0;
            cols_reg   <= '0;
            rows_reg   <= '0;
        end else if (start_ok) begin
            mode_reg   <= mode_e'(ctrl_mode);
            thresh_reg <= ctrl_thresh;
            cols_reg   <= ctrl_cols;
            rows_reg   <= ctrl_rows;
        end
    end

    // Column/row position of the next input beat; row is never wrapped since
    // the frame ends on the last row.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (start_ok) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (s_hs) begin
            if (last_col) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Sticky framing-error flags, cleared by each accepted start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_sof_reg <= 1'b0;
            err_eol_reg <= 1'b0;
        end else if (start_ok) begin
            err_sof_reg <= 1'b0;
            err_eol_reg <= 1'b0;
        end else if (s_hs) begin
            if (s_axis.tuser != first_pix) err_sof_reg <= 1'b1;
            if (s_axis.tlast != last_col)  err_eol_reg <= 1'b1;
        end
    end

    // Done pulse and sticky interrupt; a clear coinciding with completion
    // (or with the visible done pulse) loses to the set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done_reg <= 1'b0;
            irq_reg  <= 1'b0;
        end else begin
            done_reg <= done_event;
            if (done_event || done_reg) irq_reg <= 1'b1;
            else if (irq_clear)         irq_reg <= 1'b0;
        end
    end

    // Per-channel operators; channel 0 sits in the LSBs.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        axis_filter_chan_op #(
            .CH_W (CH_W)
        ) u_chan (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .advance    (s_hs),
            .first_col  (col_reg == '0),
            .second_col (col_reg == DIM_W'(1)),
            .mode       (mode_reg),
            .thresh     (thresh_reg),
            .pix_in     (s_axis.tdata[gi*CH_W +: CH_W]),
            .pix_out    (filt_data[gi*CH_W +: CH_W])
        );
    end

    // Single output stage: load on accept, hold while stalled, framing from counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_reg <= 1'b0;
            m_user_reg  <= 1'b0;
            m_last_reg  <= 1'b0;
            m_data_reg  <= '0;
        end else if (out_free) begin
            m_valid_reg <= s_hs;
            if (s_hs) begin
                m_data_reg <= filt_data;
                m_user_reg <= first_pix;
                m_last_reg <= last_col;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_reg;
    assign m_axis.tdata  = m_data_reg;
    assign m_axis.tuser  = m_user_reg;
    assign m_axis.tlast  = m_last_reg;
    assign ctrl_busy     = (state_reg != IDLE);
    assign ctrl_done     = done_reg;
    assign interrupt     = irq_reg;
    assign err_sof       = err_sof_reg;
    assign err_eol       = err_eol_reg;

endmodule

// File: tb/tb_axis_image_filter_core.sv
// Bench for axis_image_filter_core: table of per-beat vectors grouped into
// frames, plus directed sequences for backpressure, framing errors, ignored
// start, zero-size frames, interrupt set/clear priority and mid-frame reset.
module tb_axis_image_filter_core;

    localparam int CH_W  = 8;
    localparam int DIM_W = 12;

    typedef struct packed {
        logic [3:0]  grp;
        logic [1:0]  mode;
        logic [7:0]  thr;
        logic [3:0]  cols;
        logic [3:0]  rows;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             ctrl_start = 1'b0;
    logic [1:0]       ctrl_mode = 2'd0;
    logic [CH_W-1:0]  ctrl_thresh = '0;
    logic [DIM_W-1:0] ctrl_cols = '0;
    logic [DIM_W-1:0] ctrl_rows = '0;
    logic             irq_clear = 1'b0;
    logic             ctrl_busy, ctrl_done, interrupt, err_sof, err_eol;

    axis_image_filter_core_if #(.DATA_W(32)) s_axis ();
    axis_image_filter_core_if #(.DATA_W(32)) m_axis ();

    axis_image_filter_core #(
        .CHANNELS (4),
        .CH_W     (CH_W),
        .DIM_W    (DIM_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .ctrl_start  (ctrl_start),
        .ctrl_mode   (ctrl_mode),
        .ctrl_thresh (ctrl_thresh),
        .ctrl_cols   (ctrl_cols),
        .ctrl_rows   (ctrl_rows),
        .ctrl_busy   (ctrl_busy),
        .ctrl_done   (ctrl_done),
        .irq_clear   (irq_clear),
        .interrupt   (interrupt),
        .err_sof     (err_sof),
        .err_eol     (err_eol),
        .s_axis      (s_axis),
        .m_axis      (m_axis)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int start_at = -1;

    vec_t        vecs[$];
    logic [31:0] in_data[$];
    logic        in_user[$];
    logic        in_last[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_data[$];
    logic        got_user[$];
    logic        got_last[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic void add(input int g, input int m, input logic [7:0] t,
                                input int c, input int r,
                                input logic [31:0] di, input logic [31:0] dexp);
        vecs.push_back('{4'(g), 2'(m), t, 4'(c), 4'(r), di, dexp});
    endfunction

    // Correct input framing for the beats currently queued.
    task automatic set_framing(input int cols);
        in_user.delete();
        in_last.delete();
        for (int k = 0; k < in_data.size(); k++) begin
            in_user.push_back(k == 0);
            in_last.push_back((k % cols) == cols - 1);
        end
    endtask

    task automatic start_frame(input int mode, input logic [7:0] thr, input int cols, input int rows);
        @(negedge aclk);
        ctrl_mode   = 2'(mode);
        ctrl_thresh = thr;
        ctrl_cols   = DIM_W'(cols);
        ctrl_rows   = DIM_W'(rows);
        ctrl_start  = 1'b1;
        @(negedge aclk);
        ctrl_start  = 1'b0;
    endtask

    // Drive queued beats and collect output beats, sampling just after each
    // falling edge; also checks the output is held while stalled.
    task automatic run_stream(input int bp, input int max_cyc);
        int   idx = 0;
        int   cyc = 0;
        logic held_v = 1'b0;
        logic [33:0] held = '0;
        got_data.delete();
        got_user.delete();
        got_last.delete();
        while ((idx < in_data.size() || got_data.size() < in_data.size()) && cyc < max_cyc) begin
            @(negedge aclk);
            if (idx < in_data.size()) begin
                s_axis.tvalid = 1'b1;
                s_axis.tdata  = in_data[idx];
                s_axis.tuser  = in_user[idx];
                s_axis.tlast  = in_last[idx];
            end else begin
                s_axis.tvalid = 1'b0;
            end
            m_axis.tready = ($urandom_range(0, 99) >= bp);
            ctrl_start    = (cyc == start_at);
            #1;
            if (held_v)
                check("hold", {m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata}, {1'b1, held});
            if (s_axis.tvalid && s_axis.tready) idx++;
            if (m_axis.tvalid && m_axis.tready) begin
                got_data.push_back(m_axis.tdata);
                got_user.push_back(m_axis.tuser);
                got_last.push_back(m_axis.tlast);
            end
            held_v = m_axis.tvalid && !m_axis.tready;
            held   = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
            cyc++;
        end
        s_axis.tvalid = 1'b0;
        ctrl_start    = 1'b0;
        m_axis.tready = 1'b1;
    endtask

    task automatic check_beats(input string name, input int cols);
        check($sformatf("%s count", name), 64'(got_data.size()), 64'(exp_data.size()));
        for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
            check($sformatf("%s beat%0d", name, k),
                  {got_user[k], got_last[k], got_data[k]},
                  {k == 0, (k % cols) == cols - 1, exp_data[k]});
    endtask

    // Done must pulse on the cycle after the final output beat, then clear the irq.
    task automatic finish_frame(input string name);
        @(negedge aclk); #1;
        check($sformatf("%s done/busy/irq", name), {ctrl_done, ctrl_busy, interrupt}, 3'b101);
        @(negedge aclk); #1;
        check($sformatf("%s done width", name), ctrl_done, 1'b0);
        irq_clear = 1'b1;
        @(negedge aclk);
        irq_clear = 1'b0;
        #1;
        check($sformatf("%s irq clear", name), interrupt, 1'b0);
    endtask

    task automatic run_group(input int first, output int next);
        int g    = int'(vecs[first].grp);
        int cols = int'(vecs[first].cols);
        int rows = int'(vecs[first].rows);
        in_data.delete();
        exp_data.delete();
        next = first;
        while (next < vecs.size() && vecs[next].grp == vecs[first].grp) begin
            in_data.push_back(vecs[next].din);
            exp_data.push_back(vecs[next].dout);
            next++;
        end
        set_framing(cols);
        start_frame(int'(vecs[first].mode), vecs[first].thr, cols, rows);
        #1;
        check($sformatf("g%0d start", g), {ctrl_busy, err_sof, err_eol}, 3'b100);
        run_stream(0, 200);
        check_beats($sformatf("g%0d", g), cols);
        check($sformatf("g%0d errs", g), {err_sof, err_eol}, 2'b00);
        finish_frame($sformatf("g%0d", g));
        $display("[TB] group %0d mode %0d %0dx%0d: %0d beats out", g, vecs[first].mode, cols, rows, got_data.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nx;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("reset ctrl", {ctrl_busy, ctrl_done, interrupt, err_sof, err_eol}, 5'b0);
        check("reset axis", {s_axis.tready, m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata}, 36'b0);
        aresetn = 1'b1;

        // Vector table: {group, mode, thresh, cols, rows, din, dout}
        for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 4, 2, {4{8'(i)}}, {4{8'(i)}});
        add(1, 1, 8'h00, 4, 1, 32'h00000000, 32'hFFFFFFFF);
        add(1, 1, 8'h00, 4, 1, 32'h7F7F7F7F, 32'h80808080);
        add(1, 1, 8'h00, 4, 1, 32'hFFFFFFFF, 32'h00000000);
        add(1, 1, 8'h00, 4, 1, 32'h12FF007F, 32'hED00FF80);
        add(2, 2, 8'h80, 4, 1, 32'h7F7F7F7F, 32'h00000000);
        add(2, 2, 8'h80, 4, 1, 32'h80808080, 32'hFFFFFFFF);
        add(2, 2, 8'h80, 4, 1, 32'h7F80FF00, 32'h00FFFF00);
        add(2, 2, 8'h80, 4, 1, 32'h81017E80, 32'hFF0000FF);
        add(3, 3, 8'h00, 4, 2, 32'h00000000, 32'h00000000);
        add(3, 3, 8'h00, 4, 2, 32'h04040404, 32'h01010101);
        add(3, 3, 8'h00, 4, 2, 32'h08080808, 32'h04040404);
        add(3, 3, 8'h00, 4, 2, 32'h0C0C0C0C, 32'h08080808);
        for (int i = 0; i < 4; i++) add(3, 3, 8'h00, 4, 2, 32'h64646464, 32'h64646464);
        add(4, 3, 8'h00, 4, 1, 32'hFF001000, 32'hFF001000);
        add(4, 3, 8'h00, 4, 1, 32'hFF0020FF, 32'hFF001440);
        add(4, 3, 8'h00, 4, 1, 32'hFF003000, 32'hFF002080);
        add(4, 3, 8'h00, 4, 1, 32'hFF0040FF, 32'hFF003080);
        add(5, 0, 8'h00, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);
        add(5, 0, 8'h00, 1, 3, 32'h01234567, 32'h01234567);
        add(5, 0, 8'h00, 1, 3, 32'h89ABCDEF, 32'h89ABCDEF);

        nx = 0;
        while (nx < vecs.size()) run_group(nx, nx);

        // 16x16 invert frame under 50% output backpressure
        in_data.delete();
        exp_data.delete();
        for (int k = 0; k < 256; k++) begin
            in_data.push_back(32'(k) * 32'h9E3779B1);
            exp_data.push_back(~(32'(k) * 32'h9E3779B1));
        end
        set_framing(16);
        start_frame(1, 8'h00, 16, 16);
        run_stream(50, 4000);
        check_beats("bp16x16", 16);
        finish_frame("bp16x16");
        $display("[TB] backpressure frame 16x16: %0d beats out", got_data.size());

        // Wrong input tlast at col2 and a start pulse while running
        in_data.delete();
        exp_data.delete();
        for (int k = 0; k < 8; k++) begin
            in_data.push_back(32'h10203040 + 32'(k));
            exp_data.push_back(32'h10203040 + 32'(k));
        end
        set_framing(4);
        in_last[2] = 1'b1;
        start_frame(0, 8'h00, 4, 2);
        ctrl_cols = DIM_W'(2);
        ctrl_mode = 2'd1;
        start_at  = 3;
        run_stream(0, 200);
        start_at  = -1;
        check_beats("badeol", 4);
        check("badeol errs", {err_sof, err_eol}, 2'b01);
        finish_frame("badeol");
        $display("[TB] bad-tlast frame with ignored start: %0d beats out", got_data.size());

        // Missing input tuser: err_sof only; flags from the previous frame cleared by start
        in_data.delete();
        exp_data.delete();
        for (int k = 0; k < 4; k++) begin
            in_data.push_back(32'hA5A5A5A5 ^ 32'(k));
            exp_data.push_back(32'hA5A5A5A5 ^ 32'(k));
        end
        set_framing(2);
        in_user[0] = 1'b0;
        start_frame(0, 8'h00, 2, 2);
        #1;
        check("badsof start clears", {err_sof, err_eol}, 2'b00);
        run_stream(0, 200);
        check_beats("badsof", 2);
        check("badsof errs", {err_sof, err_eol}, 2'b10);
        finish_frame("badsof");
        $display("[TB] bad-tuser frame: %0d beats out", got_data.size());

        // Zero-column frame: never busy, done the cycle after start
        start_frame(0, 8'h00, 0, 3);
        #1;
        check("zero done", {ctrl_done, ctrl_busy}, 2'b10);
        @(negedge aclk); #1;
        check("zero done width", {ctrl_done, ctrl_busy, interrupt}, 3'b001);
        irq_clear = 1'b1;
        @(negedge aclk);
        irq_clear = 1'b0;
        #1;
        check("zero irq clear", interrupt, 1'b0);
        $display("[TB] zero-size frame");

        // irq_clear held through completion: set wins, then clear takes over
        in_data.delete();
        exp_data.delete();
        in_data.push_back(32'h11223344);
        in_data.push_back(32'h55667788);
        exp_data.push_back(32'h11223344);
        exp_data.push_back(32'h55667788);
        set_framing(2);
        start_frame(0, 8'h00, 2, 1);
        irq_clear = 1'b1;
        run_stream(0, 200);
        check_beats("irqprio", 2);
        @(negedge aclk); #1;
        check("irqprio set wins", {ctrl_done, interrupt}, 2'b11);
        repeat (2) @(negedge aclk);
        #1;
        check("irqprio cleared", interrupt, 1'b0);
        irq_clear = 1'b0;
        $display("[TB] irq set/clear priority frame");

        // Reset in the middle of a frame, then a clean frame
        in_data.delete();
        for (int k = 0; k < 8; k++) in_data.push_back(32'(k));
        set_framing(4);
        in_last[0] = 1'b1;
        start_frame(0, 8'h00, 4, 2);
        run_stream(0, 3);
        @(negedge aclk); #1;
        check("midreset pre", {ctrl_busy, err_eol}, 2'b11);
        aresetn = 1'b0;
        #1;
        check("midreset ctrl", {ctrl_busy, ctrl_done, interrupt, err_sof, err_eol}, 5'b0);
        check("midreset axis", {s_axis.tready, m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata}, 36'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        $display("[TB] mid-frame reset");
        run_group(0, nx);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
